// File: rtl/obstacle_pkg.sv
// Shared constants and types for the obstacle lane spawn logic.
package obstacle_pkg;

  // Game-state encodings driven by the game-state logic
  localparam logic [1:0] GS_TITLE = 2'b00;
  localparam logic [1:0] GS_RUN   = 2'b10;
  localparam logic [1:0] GS_PAUSE = 2'b01;

  // Width of one per-slot sprite select field
  localparam int unsigned SEL_W = 4;

  // 16-bit Fibonacci LFSR taps (shift left, feedback into bit 0)
  localparam int unsigned LFSR_W = 16;
  localparam int unsigned TAP_A  = 15;
  localparam int unsigned TAP_B  = 13;
  localparam int unsigned TAP_C  = 12;
  localparam int unsigned TAP_D  = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GAP  = 2'd1,
    ST_SEEK = 2'd2,
    ST_FIRE = 2'd3
  } sched_state_t;

  function automatic logic lfsr_feedback(input logic [LFSR_W-1:0] v);
    return v[TAP_A] ^ v[TAP_B] ^ v[TAP_C] ^ v[TAP_D];
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; only reset reloads the seed.
module lfsr16
  import obstacle_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] lfsr
);

  // Shift left every clock, feedback into bit 0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr <= SEED;
    else      lfsr <= {lfsr[14:0], lfsr_feedback(lfsr)};
  end

endmodule

// File: rtl/obstacle_scheduler.sv
// Spawn controller: paces obstacle releases by move ticks, picks the
// lowest free delegate slot and assigns it a pseudo-random sprite type.
module obstacle_scheduler
  import obstacle_pkg::*;
#(
  parameter int unsigned NUM_SLOTS      = 3,
  parameter logic [9:0]  MIN_GAP        = 10'd60,
  parameter int unsigned GAP_RANGE_BITS = 6,
  parameter int unsigned TYPE_COUNT     = 6,
  parameter logic [15:0] SEED           = 16'hACE1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       move_tick,
  input  logic [1:0]                 gameState,
  input  logic [NUM_SLOTS-1:0]       slot_busy,
  output logic [NUM_SLOTS-1:0]       slot_release,
  output logic [SEL_W*NUM_SLOTS-1:0] slot_sel,
  output logic [15:0]                spawn_count
);

  localparam int unsigned IDX_W      = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [15:0] RANGE_MASK = 16'((32'd1 << GAP_RANGE_BITS) - 32'd1);
  localparam logic [3:0]  TYPE_CNT   = 4'(TYPE_COUNT);

  sched_state_t     state;
  logic [9:0]       gap;
  logic [15:0]      lfsr_q;
  logic [16:0]      gap_sum;
  logic [9:0]       gap_load;
  logic [3:0]       raw_type;
  logic [3:0]       sprite_type;
  logic             free_found;
  logic [IDX_W-1:0] free_idx;

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .lfsr (lfsr_q)
  );

  // Next gap = MIN_GAP plus masked random extra, saturating at 10'h3FF
  always_comb begin
    gap_sum  = 17'(MIN_GAP) + 17'(lfsr_q & RANGE_MASK);
    gap_load = (gap_sum > 17'h003FF) ? 10'h3FF : gap_sum[9:0];
  end

  // Fold the 3-bit random value into the valid sprite type range
  always_comb begin
    raw_type    = {1'b0, lfsr_q[2:0]};
    sprite_type = (raw_type < TYPE_CNT) ? raw_type : raw_type - TYPE_CNT;
  end

  // Lowest-index slot whose busy flag is clear
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (!free_found && !slot_busy[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  // Scheduler FSM; the release pulse, sprite select and spawn count are
  // all registered on the SEEK->FIRE edge, so the FIRE cycle carries the
  // pulse and a title request on that edge suppresses it entirely.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      gap          <= MIN_GAP;
      slot_release <= '0;
      slot_sel     <= '0;
      spawn_count  <= '0;
    end else if (gameState == GS_TITLE) begin
      state        <= ST_IDLE;
      gap          <= MIN_GAP;
      slot_release <= '0;
      slot_sel     <= '0;
      spawn_count  <= '0;
    end else begin
      slot_release <= '0;
      case (state)
        ST_IDLE: begin
          if (gameState == GS_RUN) state <= ST_GAP;
        end
        ST_GAP: begin
          if (gameState == GS_RUN && move_tick) begin
            gap <= gap - 10'd1;
            if (gap == 10'd1) state <= ST_SEEK;
          end
        end
        ST_SEEK: begin
          if (gameState == GS_RUN && free_found) begin
            state                                 <= ST_FIRE;
            slot_release[free_idx]                <= 1'b1;
            slot_sel[free_idx*SEL_W +: SEL_W]     <= sprite_type;
            spawn_count                           <= spawn_count + 16'd1;
            gap                                   <= gap_load;
          end
        end
        ST_FIRE: begin
          state <= ST_GAP;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Bench for obstacle_scheduler: directed scenarios plus randomized play
// checked every cycle against a tick-countdown model of the scheduler.
module tb_obstacle_scheduler;

  localparam int         NS = 3;
  localparam logic [9:0] MG = 10'd4;
  localparam int         TC = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        move_tick = 1'b0;
  logic [1:0]  gs = 2'b00;
  logic [2:0]  busy = 3'b000;
  logic [2:0]  rel;
  logic [11:0] sel;
  logic [15:0] cnt;

  logic [1:0]  sat_gs = 2'b00;
  logic [2:0]  sat_rel;
  logic [11:0] sat_sel;
  logic [15:0] sat_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  obstacle_scheduler #(
    .NUM_SLOTS(3), .MIN_GAP(10'd4), .GAP_RANGE_BITS(0), .TYPE_COUNT(6), .SEED(16'hACE1)
  ) dut (
    .clk(clk), .rst(rst), .move_tick(move_tick), .gameState(gs), .slot_busy(busy),
    .slot_release(rel), .slot_sel(sel), .spawn_count(cnt)
  );

  obstacle_scheduler #(
    .NUM_SLOTS(3), .MIN_GAP(10'h3F0), .GAP_RANGE_BITS(6), .TYPE_COUNT(6), .SEED(16'hACE1)
  ) dut_sat (
    .clk(clk), .rst(rst), .move_tick(1'b1), .gameState(sat_gs), .slot_busy(3'b000),
    .slot_release(sat_rel), .slot_sel(sat_sel), .spawn_count(sat_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 title/idle, 1 counting ticks, 2 waiting for a free slot, 3 pulse cycle
  int          m_phase = 0;
  int          m_left = 4;
  logic [15:0] m_lfsr = 16'hACE1;
  logic [15:0] lfsr_used = 16'hACE1;
  logic [2:0]  m_rel = '0;
  logic [3:0]  m_sel [NS];
  logic [15:0] m_cnt = '0;
  int          m_releases = 0;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic logic [3:0] sprite_of(input logic [15:0] l);
    int v;
    v = int'(l[2:0]);
    if (v >= TC) v = v - TC;
    return 4'(v);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase = 0; m_left = int'(MG); m_lfsr = 16'hACE1; lfsr_used = 16'hACE1;
      m_rel = '0; m_cnt = '0;
      for (int i = 0; i < NS; i++) m_sel[i] = '0;
    end else begin
      lfsr_used = m_lfsr;
      if (gs == 2'b00) begin
        m_phase = 0; m_left = int'(MG); m_cnt = '0; m_rel = '0;
        for (int i = 0; i < NS; i++) m_sel[i] = '0;
      end else begin
        m_rel = '0;
        case (m_phase)
          0: if (gs == 2'b10) m_phase = 1;
          1: if (gs == 2'b10 && move_tick) begin
               m_left = m_left - 1;
               if (m_left == 0) m_phase = 2;
             end
          2: begin
               int k;
               k = -1;
               for (int i = NS - 1; i >= 0; i--) if (!busy[i]) k = i;
               if (gs == 2'b10 && k >= 0) begin
                 m_rel[k] = 1'b1;
                 m_sel[k] = sprite_of(m_lfsr);
                 m_cnt    = m_cnt + 16'd1;
                 m_left   = int'(MG);   // no random extra: range bits are 0
                 m_phase  = 3;
                 m_releases++;
               end
             end
          default: m_phase = 1;
        endcase
      end
      m_lfsr = lfsr_next(m_lfsr);
    end
  end

  // Every-cycle comparison against the model, plus saturated-gap check
  always @(negedge clk) begin
    if (rst) begin
      check("release", 32'(rel), 32'(m_rel));
      check("slot_sel", 32'(sel), 32'({m_sel[2], m_sel[1], m_sel[0]}));
      check("spawn_count", 32'(cnt), 32'(m_cnt));
      check("lfsr", 32'(dut.lfsr_q), 32'(m_lfsr));
      for (int i = 0; i < NS; i++)
        if (rel[i]) check("type_range", 32'(sel[4*i +: 4] < 4'(TC)), 32'd1);
      if (sat_rel != 3'b000) begin
        int e;
        e = 'h3F0 + int'(lfsr_used & 16'h003F);
        if (e > 'h3FF) e = 'h3FF;
        check("sat_gap_load", 32'(dut_sat.gap), 32'(e));
      end
    end
  end

  task automatic tick_n(input int n);
    repeat (n) begin
      move_tick = 1'b1; @(negedge clk);
      move_tick = 1'b0; @(negedge clk);
    end
  endtask

  initial begin
    logic [11:0] sel_snap;
    int seen;
    int start;
    int cyc;
    int r;
    int w;

    // Reset asserted with no clock edge yet
    #1 rst = 1'b0;
    #1;
    check("rst_release", 32'(rel), 32'd0);
    check("rst_slot_sel", 32'(sel), 32'd0);
    check("rst_count", 32'(cnt), 32'd0);
    check("rst_lfsr", 32'(dut.lfsr_q), 32'h0000ACE1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("lfsr_step1", 32'(dut.lfsr_q), 32'h000059C3);
    check("model_lfsr_step1", 32'(m_lfsr), 32'h000059C3);

    gs = 2'b10; sat_gs = 2'b10;
    @(negedge clk);

    // First release: slot 0 one cycle after the SEEK cycle
    tick_n(3);
    check("no_early_release", 32'(rel), 32'd0);
    move_tick = 1'b1; @(negedge clk); move_tick = 1'b0;
    check("seek_cycle_no_pulse", 32'(rel), 32'd0);
    @(negedge clk);
    check("first_release", 32'(rel), 32'b001);
    check("first_count", 32'(cnt), 32'd1);
    @(negedge clk);
    check("pulse_one_clk", 32'(rel), 32'd0);
    tick_n(4);
    check("second_release", 32'(rel), 32'b001);
    check("second_count", 32'(cnt), 32'd2);
    @(negedge clk);

    // Lowest free slot selection
    busy = 3'b011;
    tick_n(4);
    check("pick_slot2", 32'(rel), 32'b100);
    @(negedge clk);

    // All busy: stall without timeout, then slot 1 frees
    busy = 3'b111;
    tick_n(4);
    seen = 0;
    repeat (50) begin
      @(negedge clk);
      if (rel != 3'b000) seen++;
    end
    check("stall_no_pulse", 32'(seen), 32'd0);
    busy = 3'b101;
    @(negedge clk);
    check("unstall_slot1", 32'(rel), 32'b010);
    check("unstall_count", 32'(cnt), 32'd4);
    @(negedge clk);
    check("count_once", 32'(cnt), 32'd4);
    busy = 3'b000;

    // Pause freezes the countdown and ignores ticks
    sel_snap = sel;
    tick_n(2);
    gs = 2'b01;
    tick_n(10);
    check("pause_no_pulse", 32'(rel), 32'd0);
    check("pause_sel_hold", 32'(sel), 32'(sel_snap));
    gs = 2'b10;
    tick_n(1);
    check("resume_one_tick", 32'(rel), 32'd0);
    check("resume_sel_hold", 32'(sel), 32'(sel_snap));
    tick_n(1);
    check("resume_release", 32'(rel), 32'b001);
    check("resume_count", 32'(cnt), 32'd5);
    @(negedge clk);

    // Title request on the firing edge wins
    tick_n(3);
    move_tick = 1'b1; @(negedge clk); move_tick = 1'b0;
    gs = 2'b00;
    @(negedge clk);
    check("title_no_pulse", 32'(rel), 32'd0);
    check("title_count", 32'(cnt), 32'd0);
    check("title_gap", 32'(dut.gap), 32'(MG));
    check("title_sel", 32'(sel), 32'd0);
    gs = 2'b10;
    @(negedge clk);

    // Randomized play until 1000 more releases
    start = m_releases;
    cyc = 0;
    while ((m_releases - start) < 1000 && cyc < 40000) begin
      move_tick = ($urandom_range(0, 99) < 70);
      for (int i = 0; i < NS; i++) busy[i] = ($urandom_range(0, 3) == 0);
      r = int'($urandom_range(0, 199));
      if (r == 0)      gs = 2'b01;
      else if (r == 1) gs = 2'b11;
      else if (r == 2) gs = 2'b00;
      else if (r < 12) gs = 2'b10;
      @(negedge clk);
      cyc++;
    end
    check("random_releases_done", 32'((m_releases - start) >= 1000), 32'd1);

    // Reset asserted in the middle of a FIRE cycle
    gs = 2'b10; busy = 3'b000; move_tick = 1'b1;
    w = 0;
    while (rel == 3'b000 && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("fire_before_reset", 32'(rel != 3'b000), 32'd1);
    #1 rst = 1'b0;
    #1;
    check("midfire_release", 32'(rel), 32'd0);
    check("midfire_sel", 32'(sel), 32'd0);
    check("midfire_count", 32'(cnt), 32'd0);
    check("midfire_lfsr", 32'(dut.lfsr_q), 32'h0000ACE1);
    move_tick = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
